// File: rtl/gpr_mp_pkg.sv
// Shared types and write-port priority matching for the multi-port register file.
package gpr_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int MAX_WR     = 8;
   localparam int MAX_AW     = 16;

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } wr_hit_t;

   // Ports are scanned upward so the highest-index enabled match is the one returned.
   function automatic wr_hit_t wr_match(input logic [MAX_AW-1:0]             addr,
                                        input logic [MAX_WR-1:0]             wr_en,
                                        input logic [MAX_WR-1:0][MAX_AW-1:0] wr_addr);
      wr_hit_t r;
      r = '0;
      for (int j = 0; j < MAX_WR; j++) begin
         if (wr_en[j] && wr_addr[j] == addr) begin
            r.hit = 1'b1;
            r.idx = 3'(j);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/gpr_mp_if.sv
// Decode/writeback-facing bus of the register file: read, write and claim channels.
interface gpr_mp_if
   import gpr_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NRD    = 4,
   parameter int NWR    = 2
);
   logic [NRD*ADDR_W-1:0] rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_busy;
   logic [NWR-1:0]        wr_en;
   logic [NWR*ADDR_W-1:0] wr_addr;
   logic [NWR*DATA_W-1:0] wr_data;
   logic                  claim_en;
   logic [ADDR_W-1:0]     claim_addr;
   logic                  claim_stall;
   logic                  flush;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
      input  rd_data, rd_busy, claim_stall
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
      output rd_data, rd_busy, claim_stall
   );
endinterface

// File: rtl/gpr_mp_scoreboard.sv
// Per-register busy bits: claims set, writes release, flush clears; drives claim_stall and rd_busy.
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NRD      = 4,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic [MAX_WR-1:0]               wr_en,
   input  logic [MAX_WR-1:0][MAX_AW-1:0]   wr_addr,
   input  logic                            claim_en,
   input  logic [ADDR_W-1:0]               claim_addr,
   input  logic                            flush,
   input  logic [NRD*ADDR_W-1:0]           rd_addr,
   output logic                            claim_stall,
   output logic [NRD-1:0]                  rd_busy
);
   localparam int NREG = 2**ADDR_W;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic            stall_raw;
   wr_hit_t         claim_m;

   function automatic logic port_busy(input logic [ADDR_W-1:0] a);
      wr_hit_t m;
      logic    b;
      m = wr_match(MAX_AW'(a), wr_en, wr_addr);
      b = busy[a];
      if (BYPASS != 0 && m.hit && wr_en[m.idx]) b = 1'b0;
      return b;
   endfunction

   // Order of effects at the edge: flush, then write releases, then the accepted claim.
   always_comb begin
      claim_m   = wr_match(MAX_AW'(claim_addr), wr_en, wr_addr);
      stall_raw = claim_en && busy[claim_addr] && !(claim_m.hit && wr_en[claim_m.idx]) && !flush;
      busy_next = flush ? '0 : busy;
      for (int j = 0; j < MAX_WR; j++) begin
         if (wr_en[j]) busy_next[wr_addr[j][ADDR_W-1:0]] = 1'b0;
      end
      if (claim_en && !stall_raw && !(ZERO_REG != 0 && claim_addr == '0))
         busy_next[claim_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= '0;
      else      busy <= busy_next;
   end

   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_busy[i] = rst && port_busy(rd_addr[i*ADDR_W +: ADDR_W]);
      end
      claim_stall = rst && stall_raw;
   end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port general-purpose register file with optional write-to-read bypass and busy scoreboard.
module gpr_mp
   import gpr_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NRD      = 4,
   parameter int NWR      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
)(
   input logic     clk,
   input logic     rst,
   gpr_mp_if.slave bus
);
   localparam int NREG = 2**ADDR_W;

   logic [NREG-1:0][DATA_W-1:0]   regs;
   logic [NWR-1:0]                eff_wr_en;
   logic [MAX_WR-1:0]             ext_en;
   logic [MAX_WR-1:0][MAX_AW-1:0] ext_addr;

   // Writes to r0 are dropped here so storage, bypass and scoreboard all see the same set.
   always_comb begin
      eff_wr_en = '0;
      ext_en    = '0;
      ext_addr  = '0;
      for (int j = 0; j < NWR; j++) begin
         eff_wr_en[j] = bus.wr_en[j] &&
                        !(ZERO_REG != 0 && bus.wr_addr[j*ADDR_W +: ADDR_W] == '0);
         ext_en[j]    = eff_wr_en[j];
         ext_addr[j][ADDR_W-1:0] = bus.wr_addr[j*ADDR_W +: ADDR_W];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (eff_wr_en[j])
               regs[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      wr_hit_t           m;
      logic [DATA_W-1:0] v;
      m = wr_match(MAX_AW'(a), ext_en, ext_addr);
      v = regs[a];
      if (BYPASS != 0 && m.hit) v = bus.wr_data[int'(m.idx)*DATA_W +: DATA_W];
      if (ZERO_REG != 0 && a == '0) v = '0;
      return v;
   endfunction

   always_comb begin
      bus.rd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         bus.rd_data[i*DATA_W +: DATA_W] = rst ? read_port(bus.rd_addr[i*ADDR_W +: ADDR_W]) : '0;
      end
   end

   gpr_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NRD      (NRD),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (ext_en),
      .wr_addr     (ext_addr),
      .claim_en    (bus.claim_en),
      .claim_addr  (bus.claim_addr),
      .flush       (bus.flush),
      .rd_addr     (bus.rd_addr),
      .claim_stall (bus.claim_stall),
      .rd_busy     (bus.rd_busy)
   );

endmodule

// File: tb/tb_gpr_mp.sv
// Self-checking bench: bypassing and non-bypassing register files against an array-based model.
module tb_gpr_mp;
   import gpr_pkg::*;

   localparam int DW   = DEF_DATA_W;
   localparam int AW   = DEF_ADDR_W;
   localparam int NRD  = 4;
   localparam int NWR  = 2;
   localparam int NREG = 2**AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   reg_data_t mregs [NREG];
   bit        mbusy [NREG];

   always #10 clk = ~clk;

   gpr_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) bus0 ();
   gpr_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) bus1 ();

   assign bus1.rd_addr    = bus0.rd_addr;
   assign bus1.wr_en      = bus0.wr_en;
   assign bus1.wr_addr    = bus0.wr_addr;
   assign bus1.wr_data    = bus0.wr_data;
   assign bus1.claim_en   = bus0.claim_en;
   assign bus1.claim_addr = bus0.claim_addr;
   assign bus1.flush      = bus0.flush;

   gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1))
      dut_byp (.clk(clk), .rst(rst), .bus(bus0.slave));
   gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1))
      dut_nobyp (.clk(clk), .rst(rst), .bus(bus1.slave));

   task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic reg_addr_t rdAddr(input int i);
      return bus0.rd_addr[i*AW +: AW];
   endfunction

   function automatic reg_addr_t wrAddr(input int j);
      return bus0.wr_addr[j*AW +: AW];
   endfunction

   function automatic reg_data_t wrData(input int j);
      return bus0.wr_data[j*DW +: DW];
   endfunction

   function automatic bit writtenNow(input reg_addr_t a);
      for (int j = 0; j < NWR; j++)
         if (bus0.wr_en[j] && a != 0 && wrAddr(j) == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic reg_data_t expData(input int i, input bit byp);
      reg_addr_t a;
      reg_data_t v;
      a = rdAddr(i);
      if (!rst || a == 0) return '0;
      v = mregs[a];
      if (byp)
         for (int j = 0; j < NWR; j++)
            if (bus0.wr_en[j] && wrAddr(j) == a) v = wrData(j);
      return v;
   endfunction

   function automatic bit expBusy(input int i, input bit byp);
      reg_addr_t a;
      a = rdAddr(i);
      if (!rst) return 1'b0;
      if (byp && writtenNow(a)) return 1'b0;
      return mbusy[a];
   endfunction

   function automatic bit expStall();
      return rst && bus0.claim_en && mbusy[bus0.claim_addr] &&
             !writtenNow(bus0.claim_addr) && !bus0.flush;
   endfunction

   task automatic modelReset();
      for (int r = 0; r < NREG; r++) begin
         mregs[r] = '0;
         mbusy[r] = 1'b0;
      end
   endtask

   task automatic checkAll();
      for (int i = 0; i < NRD; i++) begin
         checkOutput($sformatf("rd_data%0d_byp", i),   bus0.rd_data[i*DW +: DW], expData(i, 1'b1));
         checkOutput($sformatf("rd_data%0d_nobyp", i), bus1.rd_data[i*DW +: DW], expData(i, 1'b0));
         checkOutput($sformatf("rd_busy%0d_byp", i),   DW'(bus0.rd_busy[i]), DW'(expBusy(i, 1'b1)));
         checkOutput($sformatf("rd_busy%0d_nobyp", i), DW'(bus1.rd_busy[i]), DW'(expBusy(i, 1'b0)));
      end
      checkOutput("claim_stall_byp",   DW'(bus0.claim_stall), DW'(expStall()));
      checkOutput("claim_stall_nobyp", DW'(bus1.claim_stall), DW'(expStall()));
   endtask

   // Check combinational outputs mid-cycle, then advance one edge and update the model.
   task automatic applyStimulus();
      bit st;
      #1;
      checkAll();
      st = expStall();
      @(posedge clk);
      if (rst) begin
         if (bus0.flush) for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
         for (int j = 0; j < NWR; j++) begin
            if (bus0.wr_en[j] && wrAddr(j) != 0) begin
               mregs[wrAddr(j)] = wrData(j);
               mbusy[wrAddr(j)] = 1'b0;
            end
         end
         if (bus0.claim_en && !st && bus0.claim_addr != 0) mbusy[bus0.claim_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic setIdle();
      bus0.wr_en      = '0;
      bus0.wr_addr    = '0;
      bus0.wr_data    = '0;
      bus0.claim_en   = 1'b0;
      bus0.claim_addr = '0;
      bus0.flush      = 1'b0;
   endtask

   task automatic setRd(input int i, input reg_addr_t a);
      bus0.rd_addr[i*AW +: AW] = a;
   endtask

   task automatic setWr(input int j, input reg_addr_t a, input reg_data_t d);
      bus0.wr_en[j]           = 1'b1;
      bus0.wr_addr[j*AW +: AW] = a;
      bus0.wr_data[j*DW +: DW] = d;
   endtask

   task automatic setClaim(input reg_addr_t a);
      bus0.claim_en   = 1'b1;
      bus0.claim_addr = a;
   endtask

   initial begin
      bus0.rd_addr = '0;
      setIdle();
      modelReset();
      #2 rst = 1'b0;

      // Reset held with random write/claim traffic.
      repeat (4) begin
         bus0.wr_en      = NWR'($urandom);
         bus0.wr_addr    = (NWR*AW)'($urandom);
         bus0.wr_data    = {$urandom, $urandom};
         bus0.claim_en   = 1'b1;
         bus0.claim_addr = AW'($urandom);
         bus0.rd_addr    = (NRD*AW)'($urandom);
         applyStimulus();
      end
      setIdle();
      rst = 1'b1;

      bus0.rd_addr = '0;
      setWr(0, 0, 32'hDEADBEEF);
      applyStimulus();
      setIdle();
      applyStimulus();

      setWr(0, 5, 32'h12345678);
      setRd(2, 5);
      applyStimulus();
      setIdle();
      applyStimulus();

      setWr(0, 7, 32'hAAAA0000);
      setWr(1, 7, 32'h5555FFFF);
      setRd(1, 7);
      applyStimulus();
      setIdle();
      applyStimulus();

      // Claim, re-claim stall, re-claim with release, then plain release.
      setClaim(9);
      setRd(0, 9);
      applyStimulus();
      applyStimulus();
      setWr(1, 9, 32'h42);
      applyStimulus();
      setIdle();
      applyStimulus();
      setWr(0, 9, 32'h42);
      applyStimulus();
      setIdle();
      applyStimulus();

      setWr(0, 3, 32'h33333333);
      applyStimulus();
      setIdle();
      setClaim(3);
      applyStimulus();
      setClaim(4);
      applyStimulus();
      setClaim(10);
      applyStimulus();
      setRd(0, 3);
      setRd(1, 4);
      setRd(2, 10);
      setRd(3, 11);
      bus0.flush = 1'b1;
      setClaim(11);
      applyStimulus();
      setIdle();
      applyStimulus();

      // Asynchronous reset between edges while r9 is busy and holds 0x42.
      setClaim(9);
      setRd(0, 9);
      applyStimulus();
      setIdle();
      applyStimulus();
      checkOutput("r9_before_reset", bus0.rd_data[0 +: DW], 32'h42);
      checkOutput("r9_busy_before_reset", DW'(bus0.rd_busy[0]), 32'd1);
      #3 rst = 1'b0;
      modelReset();
      #1;
      checkOutput("async_data", bus0.rd_data[0 +: DW], 32'h0);
      checkOutput("async_busy", DW'(bus0.rd_busy[0]), 32'd0);
      rst = 1'b1;
      #1;
      checkAll();
      @(posedge clk);
      #1;

      repeat (300) begin
         bus0.wr_en = NWR'($urandom);
         for (int j = 0; j < NWR; j++)
            setWr(j, AW'($urandom_range(0, 7)), reg_data_t'($urandom));
         bus0.wr_en      = NWR'($urandom);
         bus0.claim_en   = 1'($urandom_range(0, 1));
         bus0.claim_addr = AW'($urandom_range(0, 7));
         bus0.flush      = ($urandom_range(0, 15) == 0);
         for (int i = 0; i < NRD; i++)
            setRd(i, ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)));
         applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
